// File: rtl/mw_lmc_receiver.sv
// mw_lmc_receiver
// Far end of the STE microwire link. The serial clock, data and enable
// lines are synchronised into clk32, 11-bit frames are assembled MSB first,
// and {address, command, data} is decoded into LMC1992-style volume, tone
// and mix registers that feed the audio mixer.
//
// Serial interface: frames are framed by mw_en. A frame starts on an
// mw_en rising edge, takes one bit per mw_clk rising edge, and is committed
// on the mw_en falling edge. There is no back-pressure. upd/frm_err are
// one-cycle strobes that coincide with the new register contents.
module mw_lmc_receiver #(
  parameter logic [1:0] ADDR = 2'b10
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       mw_clk,
  input  logic       mw_data,
  input  logic       mw_en,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mix,
  output logic       upd,
  output logic       frm_err
);

  // Register reset values: master/left/right at 0 dB, tone flat.
  localparam logic [5:0] MASTER_MAX = 6'd40;
  localparam logic [4:0] SIDE_MAX   = 5'd20;
  localparam logic [3:0] TONE_MAX   = 4'd12;
  localparam logic [3:0] TONE_FLAT  = 4'd6;
  localparam logic [1:0] MIX_RST    = 2'b01;
  localparam logic [3:0] FRAME_BITS = 4'd11;

  // Command codes carried in sreg[8:6].
  localparam logic [2:0] CMD_MIX    = 3'b000;
  localparam logic [2:0] CMD_BASS   = 3'b001;
  localparam logic [2:0] CMD_TREBLE = 3'b010;
  localparam logic [2:0] CMD_MASTER = 3'b011;
  localparam logic [2:0] CMD_RIGHT  = 3'b100;
  localparam logic [2:0] CMD_LEFT   = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // FSM state is kept as a named enum so checkers can bind to it directly.
  state_t state;
  state_t state_nxt;

  // Synchroniser chains. The third clk/en flop is the edge-detect history.
  logic clk_s1, clk_s2, clk_s3;
  logic dat_s1, dat_s2;
  logic en_s1, en_s2, en_s3;

  logic clk_rise;
  logic en_rise;
  logic en_fall;

  // Frame assembly.
  logic [10:0] sreg;
  logic [3:0]  cnt;

  // FSM control strobes.
  logic clr_frame;
  logic shift_en;

  // Commit decode.
  logic       commit;
  logic       frame_ok;
  logic       addr_hit;
  logic [2:0] cmd;
  logic [5:0] d;

  logic [5:0] master_sat;
  logic [4:0] side_sat;
  logic [3:0] tone_sat;

  logic wr_mix, wr_bass, wr_treble, wr_master, wr_right, wr_left;
  logic upd_nxt;
  logic err_nxt;

  // Two-flop synchronisers plus edge history. The enable chain resets to 1
  // so a line already high at reset release is not seen as a rising edge.
  always_ff @(posedge clk32) begin
    if (reset) begin
      clk_s1 <= 1'b0;
      clk_s2 <= 1'b0;
      clk_s3 <= 1'b0;
      dat_s1 <= 1'b0;
      dat_s2 <= 1'b0;
      en_s1  <= 1'b1;
      en_s2  <= 1'b1;
      en_s3  <= 1'b1;
    end else begin
      clk_s1 <= mw_clk;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= mw_data;
      dat_s2 <= dat_s1;
      en_s1  <= mw_en;
      en_s2  <= en_s1;
      en_s3  <= en_s2;
    end
  end

  // Data shares the clock's sync depth, so dat_s2 is aligned with clk_rise.
  assign clk_rise = clk_s2 & ~clk_s3;
  assign en_rise  = en_s2 & ~en_s3;
  assign en_fall  = ~en_s2 & en_s3;

  // FSM state register.
  always_ff @(posedge clk32) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and control strobes. A bit arriving in the same cycle as
  // the enable fall is still shifted in before COMMIT.
  always_comb begin
    state_nxt = state;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (en_rise) begin
          clr_frame = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_rise) begin
          shift_en = 1'b1;
        end
        if (en_fall) begin
          state_nxt = COMMIT;
        end
      end
      COMMIT: begin
        // An enable rise landing here is dropped on purpose.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and saturating bit counter.
  always_ff @(posedge clk32) begin
    if (reset || clr_frame) begin
      sreg <= 11'd0;
      cnt  <= 4'd0;
    end else if (shift_en) begin
      sreg <= {sreg[9:0], dat_s2};
      if (cnt != 4'hF) begin
        cnt <= cnt + 4'd1;
      end
    end
  end

  assign commit   = (state == COMMIT);
  assign frame_ok = (cnt == FRAME_BITS);
  assign addr_hit = (sreg[10:9] == ADDR);
  assign cmd      = sreg[8:6];
  assign d        = sreg[5:0];

  // Clamp incoming codes to each register's legal range.
  assign master_sat = (d > MASTER_MAX)        ? MASTER_MAX : d;
  assign side_sat   = (d[4:0] > SIDE_MAX)     ? SIDE_MAX   : d[4:0];
  assign tone_sat   = (d[3:0] > TONE_MAX)     ? TONE_MAX   : d[3:0];

  // Commit decode: bad length first, then foreign address, then command.
  always_comb begin
    wr_mix    = 1'b0;
    wr_bass   = 1'b0;
    wr_treble = 1'b0;
    wr_master = 1'b0;
    wr_right  = 1'b0;
    wr_left   = 1'b0;
    upd_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (commit) begin
      if (!frame_ok) begin
        err_nxt = 1'b1;
      end else if (addr_hit) begin
        case (cmd)
          CMD_MIX:    begin wr_mix    = 1'b1; upd_nxt = 1'b1; end
          CMD_BASS:   begin wr_bass   = 1'b1; upd_nxt = 1'b1; end
          CMD_TREBLE: begin wr_treble = 1'b1; upd_nxt = 1'b1; end
          CMD_MASTER: begin wr_master = 1'b1; upd_nxt = 1'b1; end
          CMD_RIGHT:  begin wr_right  = 1'b1; upd_nxt = 1'b1; end
          CMD_LEFT:   begin wr_left   = 1'b1; upd_nxt = 1'b1; end
          default:    begin end
        endcase
      end
    end
  end

  // Output registers and strobes; values hold between commits.
  always_ff @(posedge clk32) begin
    if (reset) begin
      master_vol <= MASTER_MAX;
      left_vol   <= SIDE_MAX;
      right_vol  <= SIDE_MAX;
      bass       <= TONE_FLAT;
      treble     <= TONE_FLAT;
      mix        <= MIX_RST;
      upd        <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      if (wr_mix)    mix        <= d[1:0];
      if (wr_bass)   bass       <= tone_sat;
      if (wr_treble) treble     <= tone_sat;
      if (wr_master) master_vol <= master_sat;
      if (wr_right)  right_vol  <= side_sat;
      if (wr_left)   left_vol   <= side_sat;
      upd     <= upd_nxt;
      frm_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mw_lmc_receiver.sv
// Directed bench for mw_lmc_receiver: frames are bit-banged on the
// microwire pins and register contents, strobe counts and strobe latency
// are compared against hand-computed values.
module tb_mw_lmc_receiver;

  logic       clk32;
  logic       reset;
  logic       mw_clk;
  logic       mw_data;
  logic       mw_en;
  logic [5:0] master_vol;
  logic [4:0] left_vol;
  logic [4:0] right_vol;
  logic [3:0] bass;
  logic [3:0] treble;
  logic [1:0] mix;
  logic       upd;
  logic       frm_err;

  int checks;
  int failures;

  // Expected register image {master, left, right, bass, treble, mix}.
  logic [5:0] exp_master;
  logic [4:0] exp_left;
  logic [4:0] exp_right;
  logic [3:0] exp_bass;
  logic [3:0] exp_treble;
  logic [1:0] exp_mix;
  logic [25:0] exp_q[$];
  logic [25:0] exp_regs;
  logic [25:0] act_regs;

  mw_lmc_receiver #(.ADDR(2'b10)) dut (
    .clk32      (clk32),
    .reset      (reset),
    .mw_clk     (mw_clk),
    .mw_data    (mw_data),
    .mw_en      (mw_en),
    .master_vol (master_vol),
    .left_vol   (left_vol),
    .right_vol  (right_vol),
    .bass       (bass),
    .treble     (treble),
    .mix        (mix),
    .upd        (upd),
    .frm_err    (frm_err)
  );

  // Clock
  initial clk32 = 1'b0;
  always #5 clk32 = ~clk32;

  assign act_regs = {master_vol, left_vol, right_vol, bass, treble, mix};

  // Push the model's current register image to the expected queue.
  task automatic push_exp();
    exp_q.push_back({exp_master, exp_left, exp_right, exp_bass, exp_treble, exp_mix});
  endtask

  // Drive one bit: data settles, clock low 4 cycles, high 4 cycles.
  task automatic drive_bit(input logic b);
    mw_data = b;
    repeat (4) @(negedge clk32);
    mw_clk = 1'b1;
    repeat (4) @(negedge clk32);
    mw_clk = 1'b0;
  endtask

  // Send nbits of val MSB first; returns at the negedge where mw_en falls.
  task automatic send_frame(input logic [15:0] val, input int nbits);
    logic [15:0] v;
    v = val;
    mw_en = 1'b1;
    repeat (4) @(negedge clk32);
    for (int i = nbits - 1; i >= 0; i--) drive_bit(v[i]);
    repeat (4) @(negedge clk32);
    mw_en = 1'b0;
  endtask

  // Observe strobes for n cycles after the current negedge (cycle 1..n).
  task automatic watch(input int n, output int n_upd, output int n_err,
                       output int first_upd);
    n_upd = 0;
    n_err = 0;
    first_upd = -1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk32);
      if (upd === 1'b1) begin
        n_upd++;
        if (first_upd < 0) first_upd = c;
      end
      if (frm_err === 1'b1) n_err++;
    end
  endtask

  task automatic test_reset();
    int n_upd, n_err, first_upd;
    reset = 1'b1;
    mw_clk = 1'b0;
    mw_data = 1'b0;
    mw_en = 1'b0;
    repeat (3) @(negedge clk32);
    exp_master = 6'd40; exp_left = 5'd20; exp_right = 5'd20;
    exp_bass = 4'd6; exp_treble = 4'd6; exp_mix = 2'b01;
    push_exp();
    exp_regs = exp_q.pop_front();
    checks++;
    if (act_regs !== exp_regs) begin
      failures++;
      $display("FAIL reset_regs got %h want %h", act_regs, exp_regs);
    end
    checks++;
    if ({upd, frm_err} !== 2'b00) begin
      failures++;
      $display("FAIL reset_strobes got %b want 00", {upd, frm_err});
    end
    reset = 1'b0;
    watch(1000, n_upd, n_err, first_upd);
    checks++;
    if (n_upd !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL idle_quiet got upd=%0d err=%0d want 0/0", n_upd, n_err);
    end
    checks++;
    if (act_regs !== exp_regs) begin
      failures++;
      $display("FAIL idle_regs got %h want %h", act_regs, exp_regs);
    end
  endtask

  // A valid write: one upd exactly 4 cycles after mw_en falls, no frm_err.
  task automatic test_write(input string name, input logic [15:0] frame);
    int n_upd, n_err, first_upd;
    send_frame(frame, 11);
    watch(10, n_upd, n_err, first_upd);
    push_exp();
    exp_regs = exp_q.pop_front();
    checks++;
    if (n_upd !== 1 || first_upd !== 4 || n_err !== 0) begin
      failures++;
      $display("FAIL %s_strobe got upd=%0d at=%0d err=%0d want 1 at 4 err 0",
               name, n_upd, first_upd, n_err);
    end
    checks++;
    if (act_regs !== exp_regs) begin
      failures++;
      $display("FAIL %s_regs got %h want %h", name, act_regs, exp_regs);
    end
  endtask

  // A frame that must change nothing; want_err selects a frm_err pulse.
  task automatic test_nowrite(input string name, input logic [15:0] frame,
                              input int nbits, input int want_err);
    int n_upd, n_err, first_upd;
    send_frame(frame, nbits);
    watch(10, n_upd, n_err, first_upd);
    push_exp();
    exp_regs = exp_q.pop_front();
    checks++;
    if (n_upd !== 0 || n_err !== want_err) begin
      failures++;
      $display("FAIL %s_strobe got upd=%0d err=%0d want 0/%0d",
               name, n_upd, n_err, want_err);
    end
    checks++;
    if (act_regs !== exp_regs) begin
      failures++;
      $display("FAIL %s_regs got %h want %h", name, act_regs, exp_regs);
    end
  endtask

  task automatic test_stray_clocks();
    int n_upd, n_err;
    n_upd = 0;
    n_err = 0;
    mw_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      mw_data = i[0];
      repeat (4) @(negedge clk32);
      mw_clk = 1'b1;
      if (upd === 1'b1) n_upd++;
      if (frm_err === 1'b1) n_err++;
      repeat (4) @(negedge clk32);
      mw_clk = 1'b0;
      if (upd === 1'b1) n_upd++;
      if (frm_err === 1'b1) n_err++;
    end
    repeat (6) @(negedge clk32);
    checks++;
    if (n_upd !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL stray_strobes got upd=%0d err=%0d want 0/0", n_upd, n_err);
    end
    // 0x4E8: master = 40.
    exp_master = 6'd40;
    test_write("stray_then_master", 16'h04E8);
  endtask

  task automatic test_reset_mid_frame();
    int n_upd, n_err, first_upd;
    logic [15:0] f;
    f = 16'h04D4;
    mw_en = 1'b1;
    repeat (4) @(negedge clk32);
    for (int i = 10; i >= 5; i--) drive_bit(f[i]);
    reset = 1'b1;
    repeat (3) @(negedge clk32);
    reset = 1'b0;
    for (int i = 4; i >= 0; i--) drive_bit(f[i]);
    repeat (4) @(negedge clk32);
    mw_en = 1'b0;
    watch(10, n_upd, n_err, first_upd);
    exp_master = 6'd40; exp_left = 5'd20; exp_right = 5'd20;
    exp_bass = 4'd6; exp_treble = 4'd6; exp_mix = 2'b01;
    push_exp();
    exp_regs = exp_q.pop_front();
    checks++;
    if (n_upd !== 0 || n_err !== 0) begin
      failures++;
      $display("FAIL midreset_strobe got upd=%0d err=%0d want 0/0", n_upd, n_err);
    end
    checks++;
    if (act_regs !== exp_regs) begin
      failures++;
      $display("FAIL midreset_regs got %h want %h", act_regs, exp_regs);
    end
    // Next valid frame after a fresh enable rise is accepted.
    exp_master = 6'd20;
    test_write("after_reset_master", 16'h04D4);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    // 0x4D4: addr 10, cmd 011, d 20 -> master 20.
    exp_master = 6'd20;
    test_write("master20", 16'h04D4);
    // 0x55F: cmd 101, d 31 -> left clamps to 20.
    exp_left = 5'd20;
    test_write("left_sat", 16'h055F);
    // 0x44F: cmd 001, d 15 -> bass clamps to 12.
    exp_bass = 4'd12;
    test_write("bass_sat", 16'h044F);
    // 0x480: cmd 010, d 0 -> treble 0.
    exp_treble = 4'd0;
    test_write("treble0", 16'h0480);
    // 0x50A: cmd 100, d 10 -> right 10.
    exp_right = 5'd10;
    test_write("right10", 16'h050A);
    // 0x403: cmd 000, d 3 -> mix 11.
    exp_mix = 2'b11;
    test_write("mix3", 16'h0403);
    // Length errors, foreign address, unused command.
    test_nowrite("short10", 16'h00D4, 10, 1);
    test_nowrite("long12", 16'h09A8, 12, 1);
    test_nowrite("other_addr", 16'h02E8, 11, 0);
    test_nowrite("cmd110", 16'h058F, 11, 0);
    test_stray_clocks();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
